// File: rtl/fp_pkg.sv
// Shared constants for the FP result packing stage.
package fp_pkg;

    localparam logic [7:0]  EXP_MAX      = 8'hFF;
    localparam logic [31:0] QNAN         = 32'h7FC00000;

    localparam int          FLG_INVALID  = 2;
    localparam int          FLG_OVERFLOW = 1;
    localparam int          FLG_ZERO     = 0;

    // 32 packed data bits plus 3 flag bits
    localparam int          ENTRY_W      = 35;

endpackage

// File: rtl/fp_pack.sv
// Combinational packer: multiplier result -> IEEE-754 single word
// plus {invalid, overflow, zero} flags.
module fp_pack
    import fp_pkg::*;
(
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [23:0] frac,
    input  logic        error,
    input  logic        overflow,
    output logic [31:0] data,
    output logic [2:0]  flags
);

    // hidden bit is implied by the exponent and never stored
    logic frac_unused;
    assign frac_unused = frac[23];

    always_comb begin
        data  = {sign, exp, frac[22:0]};
        flags = 3'b000;
        if (error) begin
            data               = QNAN;
            flags[FLG_INVALID] = 1'b1;
        end else if (overflow) begin
            data                = {sign, EXP_MAX, 23'h0};
            flags[FLG_OVERFLOW] = 1'b1;
        end else if (exp == 8'h00) begin
            data            = {sign, 31'h0};
            flags[FLG_ZERO] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_pack_stage.sv
// FP pack stage: packs results, buffers them in a small FIFO and
// accumulates sticky exception flags.
module fp_pack_stage
    import fp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [23:0] in_frac,
    input  logic        in_error,
    input  logic        in_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags,
    input  logic        flags_clr,
    output logic [2:0]  sticky_flags
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [31:0]        pack_data;
    logic [2:0]         pack_flags;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sticky_q, sticky_d;
    logic             push, pop;

    fp_pack u_pack (
        .sign     (in_sign),
        .exp      (in_exp),
        .frac     (in_frac),
        .error    (in_error),
        .overflow (in_overflow),
        .data     (pack_data),
        .flags    (pack_flags)
    );

    // ready depends only on registered count, never on out_ready
    assign in_ready  = (cnt_q != FULL);
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head         = mem_q[rd_ptr_q];
    assign out_data     = out_valid ? head[34:3] : 32'h0;
    assign out_flags    = out_valid ? head[2:0] : 3'b000;
    assign sticky_flags = sticky_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (flags_clr) begin
            sticky_d = 3'b000;
        end
        if (push) begin
            sticky_d = sticky_d | pack_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            sticky_q <= 3'b000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {pack_data, pack_flags};
        end
    end

endmodule

// File: doc/fp_pack_stage.md
FP_PACK_STAGE -- requirements
Module: fp_pack_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2: number of buffered result entries; legal values are powers of two, 2 or more.
REQ-002 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1: an upstream multiplier result is present.
REQ-005 SHALL have port in_ready  output  1: the stage can accept a result this cycle.
REQ-006 SHALL have port in_sign  input  1: result sign.
REQ-007 SHALL have port in_exp  input  8: biased result exponent.
REQ-008 SHALL have port in_frac  input  24: significand; bit 23 is the hidden bit, bits 22:0 are the stored fraction.
REQ-009 SHALL have port in_error  input  1: invalid operation (inf*0).
REQ-010 SHALL have port in_overflow  input  1: exponent overflow.
REQ-011 SHALL have port out_valid  output  1: out_data and out_flags hold a packed result.
REQ-012 SHALL have port out_ready  input  1: downstream accepts the result this cycle.
REQ-013 SHALL have port out_data  output  32: packed IEEE-754 single-precision word.
REQ-014 SHALL have port out_flags  output  3: flags for the head entry, ordered {invalid, overflow, zero}.
REQ-015 SHALL have port flags_clr  input  1: synchronous clear of the sticky flags.
REQ-016 SHALL have port sticky_flags  output  3: accumulated flags, same bit order as out_flags.

Function
REQ-017 Packing SHALL follow this priority; the first matching row applies:
- in_error=1: out_data = 32'h7FC00000 (canonical quiet NaN, sign 0).
- in_overflow=1: out_data = {in_sign, 8'hFF, 23'h0}.
- in_exp=0: out_data = {in_sign, 31'h0}.
- otherwise: out_data = {in_sign, in_exp, in_frac[22:0]}.
REQ-018 Exponent 8'hFF with in_error=0 SHALL pack as {in_sign, 8'hFF, in_frac[22:0]}, so inf*inf passes through as inf.
REQ-019 Flags SHALL be computed as:
- invalid = in_error.
- overflow = in_overflow & ~in_error.
- zero = (in_exp==0) & ~in_error & ~in_overflow.
REQ-020 Packing and flag computation SHALL happen before storage; each buffer entry holds 32 data bits plus 3 flag bits.
REQ-021 A push SHALL occur when in_valid & in_ready; a pop SHALL occur when out_valid & out_ready.
REQ-022 in_ready SHALL equal (count != DEPTH), with no combinational path from out_ready; a full buffer stalls for one cycle even when a pop occurs in that cycle.
REQ-023 out_valid SHALL equal (count != 0).
REQ-024 When empty, out_data and out_flags SHALL be 0.
REQ-025 Latency SHALL be 1 cycle: a result pushed at edge N is visible on out_data after edge N.
REQ-026 Results SHALL leave in push order.
REQ-027 Simultaneous push and pop when not full and not empty SHALL leave count unchanged.
REQ-028 Simultaneous push and pop when empty is not possible; the pushed entry appears the next cycle.
REQ-029 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-030 With out_valid=1 and out_ready=0, out_data and out_flags SHALL stay stable.
REQ-031 sticky_flags SHALL OR in the flags of every pushed entry on each push.
REQ-032 flags_clr SHALL zero sticky_flags at the next edge; if a push occurs in the same cycle, sticky_flags SHALL take that entry's flags only.
REQ-033 Input fields SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-034 While rst_n=0, the block SHALL be held in reset:
- out_valid=0 and in_ready=1.
- out_data=0, out_flags=0 and sticky_flags=0.
- Pointers and count at 0.
REQ-035 Assertion of rst_n mid-transfer SHALL discard all buffered entries immediately, without waiting for clk.
REQ-036 Buffer storage contents need not be reset.

Structure
REQ-037 Shared package fp_pkg SHALL hold:
- EXP_MAX = 8'hFF and QNAN = 32'h7FC00000.
- Flag bit indices FLG_INVALID=2, FLG_OVERFLOW=1, FLG_ZERO=0.
- The 35-bit buffer-entry width constant.
REQ-038 Combinational packing and flag logic SHALL be a sub-module named fp_pack; fp_pack_stage instantiates it together with the buffer, handshake and sticky logic.

Verification
REQ-039 Normal result: push sign=0, exp=8'h80, frac=24'hC00000 -> after one cycle out_data=32'h40400000 (3.0), out_flags=3'b000.
REQ-040 Exceptions in consecutive cycles, with out_ready=1:
- push error=1 -> out_data=32'h7FC00000, flags=3'b100.
- push overflow=1, sign=1 -> out_data=32'hFF800000, flags=3'b010.
- push exp=0, sign=1 -> out_data=32'h80000000, flags=3'b001.
- then sticky_flags=3'b111.
REQ-041 Backpressure: out_ready=0, push three results with DEPTH=2 -> in_ready falls after two pushes; out_data holds the first result steady; with out_ready=1, results drain in order.
REQ-042 Flag clear: pulse flags_clr while pushing an invalid result -> sticky_flags=3'b100; previous overflow bit is cleared.
REQ-043 Reset mid-flight: two entries buffered, drop rst_n between edges -> out_valid=0 and in_ready=1 immediately, and no stale output appears after release.
REQ-044 Wrap-around: 10 back-to-back pushes with out_ready=1 -> 10 results out, in order, each one cycle after its push, count never exceeds 1.
